// File: rtl/sys_io_ctrl_pkg.sv
// Shared definitions for the syscall I/O controller: op codes, op width and FSM state encoding.
// SYS_OP_LENGTH mirrors the CPU's instruction header so both sides agree on the op field width.
package sys_io_ctrl_pkg;

    localparam int unsigned SYS_OP_LENGTH = 2;

    localparam logic [SYS_OP_LENGTH-1:0] SYS_PRINT_INT  = 2'd0;
    localparam logic [SYS_OP_LENGTH-1:0] SYS_READ_INT   = 2'd1;
    localparam logic [SYS_OP_LENGTH-1:0] SYS_PRINT_CHAR = 2'd2;
    localparam logic [SYS_OP_LENGTH-1:0] SYS_EXIT       = 2'd3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StOutWait = 3'd1,
        StInWait  = 3'd2,
        StRelease = 3'd3,
        StHalted  = 3'd4
    } sys_state_e;

    // True for the two ops that push a word to the console.
    function automatic logic is_print_op(input logic [SYS_OP_LENGTH-1:0] op);
        return (op == SYS_PRINT_INT) || (op == SYS_PRINT_CHAR);
    endfunction

endpackage

// File: rtl/sys_io_ctrl_if.sv
// Bundle of the CPU-side syscall signals and the console valid/ready channels.
// The controller takes the slave view; the CPU/console side (or a bench) takes the master view.
interface sys_io_ctrl_if #(
    parameter int unsigned SYS_OP_W = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = 32
);

    // CPU side
    logic                syscall;
    logic [SYS_OP_W-1:0] sys_op;
    logic [DATA_W-1:0]   sys_inf_out;
    logic                cpu_halt;
    logic [DATA_W-1:0]   sys_inf_in;
    logic                cpu_en;

    // Console output channel
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_char;
    logic                out_ready;

    // Console input channel
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;

    // Status
    logic                halted;
    logic [CNT_W-1:0]    retired;

    modport slave (
        input  syscall, sys_op, sys_inf_out, cpu_halt, out_ready, in_valid, in_data,
        output sys_inf_in, cpu_en, out_valid, out_data, out_char, in_ready, halted, retired
    );

    modport master (
        output syscall, sys_op, sys_inf_out, cpu_halt, out_ready, in_valid, in_data,
        input  sys_inf_in, cpu_en, out_valid, out_data, out_char, in_ready, halted, retired
    );

endinterface

// File: rtl/sys_io_ctrl.sv
// Syscall I/O controller sitting downstream of the single-cycle CPU.
// Freezes the CPU via cpu_en while a console transaction is in flight, then opens exactly one
// commit edge (RELEASE) so the CPU retires the syscall and writes any read data.
module sys_io_ctrl
    import sys_io_ctrl_pkg::*;
#(
    parameter int unsigned SYS_OP_W = SYS_OP_LENGTH,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    sys_io_ctrl_if.slave   bus
);

    sys_state_e          state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_char_q, out_char_d;
    logic [DATA_W-1:0]   sys_inf_in_q, sys_inf_in_d;
    logic [CNT_W-1:0]    retired_q;
    logic                cpu_en;
    logic [SYS_OP_W-1:0] op;

    assign op = bus.sys_op;

    // State and data registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            out_data_q   <= '0;
            out_char_q   <= 1'b0;
            sys_inf_in_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_char_q   <= out_char_d;
            sys_inf_in_q <= sys_inf_in_d;
        end
    end

    // Next-state, data capture and the CPU clock-enable decode.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_char_d   = out_char_q;
        sys_inf_in_d = sys_inf_in_q;
        cpu_en       = 1'b0;

        case (state_q)
            StIdle: begin
                // Ordinary instructions commit in their own cycle.
                cpu_en = !bus.syscall && !bus.cpu_halt;
                if (bus.cpu_halt) begin
                    state_d = StHalted;
                end else if (bus.syscall) begin
                    if (is_print_op(op)) begin
                        out_data_d = bus.sys_inf_out;
                        out_char_d = (op == SYS_PRINT_CHAR);
                        state_d    = StOutWait;
                    end else if (op == SYS_READ_INT) begin
                        state_d = StInWait;
                    end else begin
                        // EXIT and anything unrecognised stop the CPU.
                        state_d = StHalted;
                    end
                end
            end
            StOutWait: begin
                if (bus.out_ready) begin
                    state_d = StRelease;
                end
            end
            StInWait: begin
                if (bus.in_valid) begin
                    sys_inf_in_d = bus.in_data;
                    state_d      = StRelease;
                end
            end
            StRelease: begin
                // syscall is still high here for the same instruction; never re-decode it.
                cpu_en  = 1'b1;
                state_d = StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StHalted;
            end
        endcase
    end

    // Retired-instruction counter: one tick per edge on which the CPU commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (cpu_en) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Handshake flags decode straight from the state register so reset clears them at once.
    assign bus.out_valid  = (state_q == StOutWait);
    assign bus.in_ready   = (state_q == StInWait);
    assign bus.halted     = (state_q == StHalted);
    assign bus.cpu_en     = cpu_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_char   = out_char_q;
    assign bus.sys_inf_in = sys_inf_in_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_sys_io_ctrl.sv
// Directed bench for sys_io_ctrl. Stimulus pushes expected console words and expected release
// read-back values into queues; a negedge monitor compares whatever the DUT presents.
module tb_sys_io_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          chr;
    } out_exp_t;

    logic clk;
    logic rst;

    sys_io_ctrl_if #(.SYS_OP_W(2), .DATA_W(DW), .CNT_W(CW)) bus ();

    sys_io_ctrl #(.SYS_OP_W(2), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    out_exp_t      out_q[$];
    logic [DW-1:0] rel_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare presented console words and release read-back against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.out_valid) begin
                    if (out_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got 0x%0h expected none", bus.out_data);
                    end else begin
                        check("out_data", 64'(bus.out_data), 64'(out_q[0].data));
                        check("out_char", 64'(bus.out_char), 64'(out_q[0].chr));
                        if (bus.out_ready) void'(out_q.pop_front());
                    end
                end
                if (bus.cpu_en && bus.syscall) begin
                    if (rel_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_release: got release expected none");
                    end else begin
                        check("release_sys_inf_in", 64'(bus.sys_inf_in), 64'(rel_q.pop_front()));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        bus.syscall     = 1'b0;
        bus.sys_op      = '0;
        bus.sys_inf_out = '0;
        bus.cpu_halt    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;

        // Reset state
        next();
        next();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        check("rst_retired", 64'(bus.retired), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_char", 64'(bus.out_char), 64'd0);
        check("rst_sys_inf_in", 64'(bus.sys_inf_in), 64'd0);
        check("rst_cpu_en", 64'(bus.cpu_en), 64'd1);
        rst = 1'b1;

        // Plain instructions
        for (int i = 1; i <= 3; i++) begin
            next();
            check("plain_retired", 64'(bus.retired), 64'(i));
            check("plain_cpu_en", 64'(bus.cpu_en), 64'd1);
            check("plain_out_valid", 64'(bus.out_valid), 64'd0);
            check("plain_in_ready", 64'(bus.in_ready), 64'd0);
        end

        // PRINT_INT 0x2A with out_ready held low for 3 cycles
        bus.syscall     = 1'b1;
        bus.sys_op      = 2'd0;
        bus.sys_inf_out = 32'h0000_002A;
        out_q.push_back('{data: 32'h0000_002A, chr: 1'b0});
        rel_q.push_back(32'h0);
        #1;
        check("pint_entry_cpu_en", 64'(bus.cpu_en), 64'd0);
        next();
        bus.sys_inf_out = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            check("pint_out_valid", 64'(bus.out_valid), 64'd1);
            check("pint_cpu_en", 64'(bus.cpu_en), 64'd0);
            check("pint_retired", 64'(bus.retired), 64'd3);
            if (k == 3) bus.out_ready = 1'b1;
            next();
        end
        check("pint_rel_cpu_en", 64'(bus.cpu_en), 64'd1);
        check("pint_rel_out_valid", 64'(bus.out_valid), 64'd0);
        check("pint_rel_retired", 64'(bus.retired), 64'd3);
        bus.out_ready = 1'b0;
        next();
        bus.syscall = 1'b0;
        #1;
        check("pint_done_retired", 64'(bus.retired), 64'd4);
        check("pint_done_cpu_en", 64'(bus.cpu_en), 64'd1);

        // READ_INT, in_valid two cycles after entry
        bus.syscall = 1'b1;
        bus.sys_op  = 2'd1;
        rel_q.push_back(32'hDEAD_BEEF);
        next();
        check("rint_in_ready0", 64'(bus.in_ready), 64'd1);
        check("rint_cpu_en0", 64'(bus.cpu_en), 64'd0);
        next();
        check("rint_in_ready1", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        next();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h1234_5678;
        check("rint_rel_in_ready", 64'(bus.in_ready), 64'd0);
        check("rint_rel_cpu_en", 64'(bus.cpu_en), 64'd1);
        check("rint_rel_data", 64'(bus.sys_inf_in), 64'hDEAD_BEEF);
        check("rint_rel_retired", 64'(bus.retired), 64'd4);
        next();
        bus.syscall = 1'b0;
        check("rint_done_retired", 64'(bus.retired), 64'd5);
        check("rint_hold_data", 64'(bus.sys_inf_in), 64'hDEAD_BEEF);

        // PRINT_CHAR 'A' with out_ready tied high
        bus.out_ready   = 1'b1;
        bus.syscall     = 1'b1;
        bus.sys_op      = 2'd2;
        bus.sys_inf_out = 32'h0000_0041;
        out_q.push_back('{data: 32'h0000_0041, chr: 1'b1});
        rel_q.push_back(32'hDEAD_BEEF);
        next();
        check("pchr_out_valid", 64'(bus.out_valid), 64'd1);
        check("pchr_out_char", 64'(bus.out_char), 64'd1);
        next();
        check("pchr_rel_cpu_en", 64'(bus.cpu_en), 64'd1);
        check("pchr_rel_out_valid", 64'(bus.out_valid), 64'd0);
        next();
        check("pchr_no_dup", 64'(bus.out_valid), 64'd0);
        check("pchr_retired", 64'(bus.retired), 64'd6);
        bus.syscall   = 1'b0;
        bus.out_ready = 1'b0;
        next();
        check("plain2_retired", 64'(bus.retired), 64'd7);
        check("out_q_drained", 64'(out_q.size()), 64'd0);
        check("rel_q_drained", 64'(rel_q.size()), 64'd0);

        // EXIT
        bus.syscall = 1'b1;
        bus.sys_op  = 2'd3;
        next();
        for (int k = 0; k < 3; k++) begin
            bus.out_ready = k[0];
            bus.in_valid  = ~k[0];
            check("exit_halted", 64'(bus.halted), 64'd1);
            check("exit_cpu_en", 64'(bus.cpu_en), 64'd0);
            check("exit_retired", 64'(bus.retired), 64'd7);
            check("exit_out_valid", 64'(bus.out_valid), 64'd0);
            check("exit_in_ready", 64'(bus.in_ready), 64'd0);
            next();
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;

        // Fresh run: cpu_halt together with a PRINT_INT syscall, halt must win
        rst = 1'b0;
        #1;
        check("rst2_halted", 64'(bus.halted), 64'd0);
        check("rst2_retired", 64'(bus.retired), 64'd0);
        next();
        rst          = 1'b1;
        bus.syscall  = 1'b1;
        bus.cpu_halt = 1'b1;
        bus.sys_op   = 2'd0;
        #1;
        check("halt_entry_cpu_en", 64'(bus.cpu_en), 64'd0);
        next();
        check("halt_halted", 64'(bus.halted), 64'd1);
        check("halt_out_valid", 64'(bus.out_valid), 64'd0);
        bus.syscall  = 1'b0;
        bus.cpu_halt = 1'b0;
        next();
        next();
        check("halt_sticky", 64'(bus.halted), 64'd1);
        check("halt_retired", 64'(bus.retired), 64'd0);

        // Reset while waiting in OUT_WAIT
        rst = 1'b0;
        next();
        rst = 1'b1;
        next();
        check("rst3_retired", 64'(bus.retired), 64'd1);
        bus.syscall     = 1'b1;
        bus.sys_op      = 2'd0;
        bus.sys_inf_out = 32'h0000_0055;
        out_q.push_back('{data: 32'h0000_0055, chr: 1'b0});
        next();
        check("abort_out_valid_pre", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_out_valid_async", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready_async", 64'(bus.in_ready), 64'd0);
        out_q.delete();
        rel_q.delete();
        bus.syscall = 1'b0;
        next();
        rst = 1'b1;
        #1;
        check("abort_idle_cpu_en", 64'(bus.cpu_en), 64'd1);
        check("abort_retired", 64'(bus.retired), 64'd0);
        check("abort_sys_inf_in", 64'(bus.sys_inf_in), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        next();
        check("abort_retired_run", 64'(bus.retired), 64'd1);

        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
